// File: rtl/bnn_loader_pkg.sv
// Shared types and constants for the BNN instruction-SRAM loader.
// No logic; state encoding, SRAM control field positions, program size limit.
// Backpressure: n/a.
package bnn_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
`ifdef BNN_LOADER_CSUM_EN
        ST_CSUM  = 3'd3,
`endif
        ST_FLUSH = 3'd4,
        ST_RUN   = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    localparam int ADDR_LSB = 0;
    localparam int CEN_BIT  = 11;
    localparam int WEN_BIT  = 12;
    localparam int MAX_LEN  = 2048;

endpackage

// File: rtl/bnn_loader_csum.sv
// Modulo-2^W running sum of loaded words with an equality compare.
// Latency: sum updates one cycle after i_add; o_match is combinational.
// Backpressure: none; the parent qualifies i_add with the handshake.
module bnn_loader_csum
    import bnn_loader_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_add,
    input  logic [W-1:0] i_dat,
    input  logic [W-1:0] i_cmp_dat,
    output logic         o_match
);

    logic [W-1:0] r_sum;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_sum <= '0;
        end else if (i_add) begin
            r_sum <= r_sum + i_dat;
        end
    end

    assign o_match = (r_sum == i_cmp_dat);

endmodule

// File: rtl/bnn_inst_loader.sv
// Loads a length-prefixed word stream into instruction SRAM, then releases the controller.
// Latency: write one cycle after each handshake; RUN two cycles after the final word.
// Backpressure: s_ready is a state decode; stalls on s_valid low. Checksum stage: BNN_LOADER_CSUM_EN.
module bnn_inst_loader
    import bnn_loader_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [ADDR_W+1:0] ctrl_instsram_ctrl,
    output logic [ADDR_W+1:0] instsram_ctrl,
    output logic [DATA_W-1:0] instsram_wdata,
    output logic              ctrl_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [31:0] LEN_LIMIT = 32'(1) << ADDR_W;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_left;
    logic              r_wr_vld;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_dat;
    logic              w_hs;
    logic              w_start;
    logic              w_last;
    logic              w_len_bad;
    logic [31:0]       w_len;

    assign w_hs      = s_valid & s_ready;
    assign w_start   = start & ((r_state == ST_IDLE) || (r_state == ST_RUN) || (r_state == ST_ERR));
    assign w_len     = 32'(s_data);
    assign w_len_bad = (w_len == 32'd0) || (w_len > LEN_LIMIT);
    assign w_last    = (r_left == (ADDR_W+1)'(1));

`ifdef BNN_LOADER_CSUM_EN
    logic w_csum_ok;

    bnn_loader_csum #(
        .W (DATA_W)
    ) u_csum (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_start),
        .i_add     (w_hs && (r_state == ST_DATA)),
        .i_dat     (s_data),
        .i_cmp_dat (s_data),
        .o_match   (w_csum_ok)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (start) w_state_nxt = ST_HDR;
            end
            ST_HDR: begin
                if (w_hs) w_state_nxt = w_len_bad ? ST_ERR : ST_DATA;
            end
            ST_DATA: begin
`ifdef BNN_LOADER_CSUM_EN
                if (w_hs && w_last) w_state_nxt = ST_CSUM;
`else
                if (w_hs && w_last) w_state_nxt = ST_FLUSH;
`endif
            end
`ifdef BNN_LOADER_CSUM_EN
            ST_CSUM: begin
                if (w_hs) w_state_nxt = w_csum_ok ? ST_FLUSH : ST_ERR;
            end
`endif
            ST_FLUSH: w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Write pipeline: a handshake at cycle t becomes a one-cycle SRAM write at t+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_left    <= '0;
            r_wr_vld  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_dat  <= '0;
        end else begin
            r_wr_vld <= 1'b0;
            if (w_start) begin
                r_addr <= '0;
            end
            if ((r_state == ST_HDR) && w_hs) begin
                r_left <= w_len[ADDR_W:0];
            end
            if ((r_state == ST_DATA) && w_hs) begin
                r_wr_vld  <= 1'b1;
                r_wr_addr <= r_addr;
                r_wr_dat  <= s_data;
                r_addr    <= r_addr + 1'b1;
                r_left    <= r_left - 1'b1;
            end
        end
    end

    always_comb begin
        instsram_ctrl                       = '0;
        instsram_ctrl[ADDR_LSB +: ADDR_W]   = r_wr_addr;
        instsram_ctrl[CEN_BIT]              = ~r_wr_vld;
        instsram_ctrl[WEN_BIT]              = ~r_wr_vld;
        if (r_state == ST_RUN) begin
            instsram_ctrl = ctrl_instsram_ctrl;
        end
    end

`ifdef BNN_LOADER_CSUM_EN
    assign s_ready = (r_state == ST_HDR) || (r_state == ST_DATA) || (r_state == ST_CSUM);
    assign busy    = s_ready || (r_state == ST_FLUSH);
`else
    assign s_ready = (r_state == ST_HDR) || (r_state == ST_DATA);
    assign busy    = s_ready || (r_state == ST_FLUSH);
`endif

    assign instsram_wdata = r_wr_dat;
    // A restart from RUN must hold the controller in reset before the first write lands.
    assign ctrl_rst       = (r_state != ST_RUN) | start;
    assign done           = (r_state == ST_RUN);
    assign err            = (r_state == ST_ERR);

endmodule
